// File: rtl/sound_pkg.sv
// Shared definitions for the sound sequencer and sound player.
package sound_pkg;

    localparam int SAMPLE_W    = 10;
    localparam int DIV_DEFAULT = 3125;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        HOLD,
        LAST
    } state_t;

endpackage

// File: rtl/sample_tick_gen.sv
// Sample-period tick source: counts 0..DIV-1 while enabled; clear restarts the period.
// Latency: tick is decoded combinationally from the count register.
// Backpressure: none; advances on every enabled cycle.
module sample_tick_gen
    import sound_pkg::*;
#(
    parameter int DIV = DIV_DEFAULT
) (
    input  logic clk,
    input  logic reset_n_clk,
    input  logic clear,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == LAST_CNT) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n_clk) begin
        if (!reset_n_clk) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST_CNT);

endmodule

// File: rtl/sound_sequencer.sv
// Plays samples start..end from memory, one per DIV-cycle period, optionally looping.
// Latency: first sample reaches read_data DIV+1 cycles after the play request.
// Backpressure: none; play is ignored while busy, stop aborts on the next cycle.
module sound_sequencer
    import sound_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DIV    = DIV_DEFAULT
) (
    input  logic                clk,
    input  logic                reset_n_clk,
    input  logic                play_req,
    input  logic                stop_req,
    input  logic [ADDR_W-1:0]   start_addr,
    input  logic [ADDR_W-1:0]   end_addr,
    input  logic                loop_en,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_rd_en,
    input  logic [SAMPLE_W-1:0] mem_rdata,
    output logic [SAMPLE_W-1:0] read_data,
    output logic                sound_enable_n,
    output logic                busy,
    output logic                done,
    output logic                err
);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   start_q, start_d;
    logic [ADDR_W-1:0]   end_q, end_d;
    logic                loop_q, loop_d;
    logic [SAMPLE_W-1:0] next_q, next_d;
    logic [SAMPLE_W-1:0] read_data_q, read_data_d;
    logic                snd_en_n_q, snd_en_n_d;
    logic                rd_en_q, rd_en_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                tick, cnt_clear, cnt_en;

    assign cnt_en = (state_q != IDLE);

    sample_tick_gen #(.DIV(DIV)) u_tick (
        .clk         (clk),
        .reset_n_clk (reset_n_clk),
        .clear       (cnt_clear),
        .en          (cnt_en),
        .tick        (tick)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        start_d     = start_q;
        end_d       = end_q;
        loop_d      = loop_q;
        next_d      = next_q;
        read_data_d = read_data_q;
        snd_en_n_d  = snd_en_n_q;
        rd_en_d     = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;
        cnt_clear   = 1'b0;

        case (state_q)
            IDLE: begin
                if (play_req) begin
                    if (start_addr <= end_addr) begin
                        start_d   = start_addr;
                        end_d     = end_addr;
                        loop_d    = loop_en;
                        addr_d    = start_addr;
                        cnt_clear = 1'b1;
                        rd_en_d   = 1'b1;
                        state_d   = FETCH;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            FETCH: state_d = WAIT;
            WAIT: begin
                next_d  = mem_rdata;
                state_d = HOLD;
            end
            HOLD: begin
                if (tick) begin
                    read_data_d = next_q;
                    snd_en_n_d  = 1'b0;
                    if (addr_q != end_q) begin
                        addr_d  = addr_q + ADDR_W'(1);
                        rd_en_d = 1'b1;
                        state_d = FETCH;
                    end else if (loop_q) begin
                        addr_d  = start_q;
                        rd_en_d = 1'b1;
                        state_d = FETCH;
                    end else begin
                        state_d = LAST;
                    end
                end
            end
            LAST: begin
                if (tick) begin
                    read_data_d = '0;
                    snd_en_n_d  = 1'b1;
                    done_d      = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort overrides whatever the sample period would have done this cycle.
        if (stop_req && state_q != IDLE) begin
            state_d     = IDLE;
            read_data_d = '0;
            snd_en_n_d  = 1'b1;
            rd_en_d     = 1'b0;
            done_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n_clk) begin
        if (!reset_n_clk) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            start_q     <= '0;
            end_q       <= '0;
            loop_q      <= 1'b0;
            next_q      <= '0;
            read_data_q <= '0;
            snd_en_n_q  <= 1'b1;
            rd_en_q     <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            start_q     <= start_d;
            end_q       <= end_d;
            loop_q      <= loop_d;
            next_q      <= next_d;
            read_data_q <= read_data_d;
            snd_en_n_q  <= snd_en_n_d;
            rd_en_q     <= rd_en_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign mem_addr       = addr_q;
    assign mem_rd_en      = rd_en_q;
    assign read_data      = read_data_q;
    assign sound_enable_n = snd_en_n_q;
    assign done           = done_q;
    assign err            = err_q;
    assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_sound_sequencer.sv
// Scoreboard bench: stimulus predicts output events (cycle-stamped), a negedge monitor pops and compares.
module tb_sound_sequencer;

    localparam int AW       = 8;
    localparam int DV       = 4;
    localparam int DV_LONG  = 3125;
    localparam int K_OUT    = 0;
    localparam int K_FETCH  = 1;
    localparam int K_DONE   = 2;
    localparam int K_ERR    = 3;
    localparam int IDLE_OUT = 1024;

    typedef struct {
        int kind;
        int val;
        int t;
    } ev_t;

    logic          clk = 1'b0;
    logic          reset_n_clk;
    logic          play_req, stop_req, loop_en;
    logic [AW-1:0] start_addr, end_addr, mem_addr;
    logic          mem_rd_en;
    logic [9:0]    mem_rdata, read_data;
    logic          sound_enable_n, busy, done, err;

    logic          play_l, stop_l, loop_l;
    logic [AW-1:0] start_l, end_l, addr_l;
    logic          rd_en_l;
    logic [9:0]    rdata_l, read_data_l;
    logic          en_n_l, busy_l, done_l, err_l;

    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    int   busy_lo = 1;
    int   busy_hi = 0;
    int   model_out = IDLE_OUT;
    int   mon_prev = IDLE_OUT;
    bit   mon_en = 1'b0;
    ev_t  exp_q[$];

    sound_sequencer #(.ADDR_W(AW), .DIV(DV)) u_dut (
        .clk            (clk),
        .reset_n_clk    (reset_n_clk),
        .play_req       (play_req),
        .stop_req       (stop_req),
        .start_addr     (start_addr),
        .end_addr       (end_addr),
        .loop_en        (loop_en),
        .mem_addr       (mem_addr),
        .mem_rd_en      (mem_rd_en),
        .mem_rdata      (mem_rdata),
        .read_data      (read_data),
        .sound_enable_n (sound_enable_n),
        .busy           (busy),
        .done           (done),
        .err            (err)
    );

    sound_sequencer #(.ADDR_W(AW), .DIV(DV_LONG)) u_dut_long (
        .clk            (clk),
        .reset_n_clk    (reset_n_clk),
        .play_req       (play_l),
        .stop_req       (stop_l),
        .start_addr     (start_l),
        .end_addr       (end_l),
        .loop_en        (loop_l),
        .mem_addr       (addr_l),
        .mem_rd_en      (rd_en_l),
        .mem_rdata      (rdata_l),
        .read_data      (read_data_l),
        .sound_enable_n (en_n_l),
        .busy           (busy_l),
        .done           (done_l),
        .err            (err_l)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [9:0] mem_val(input int a);
        return 10'((10 * a) % 1024);
    endfunction

    // Memory returns data one cycle after the strobe, garbage otherwise.
    always @(posedge clk) begin
        mem_rdata <= mem_rd_en ? mem_val(int'(mem_addr)) : 10'($urandom);
        rdata_l   <= rd_en_l   ? mem_val(int'(addr_l))   : 10'($urandom);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push_ev(input int kind, input int val, input int t);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        e.t    = t;
        exp_q.push_back(e);
    endtask

    task automatic push_out(input int t, input int en_n, input int v);
        int o;
        o = en_n * 1024 + v;
        if (o != model_out) push_ev(K_OUT, o, t);
        model_out = o;
    endtask

    task automatic check_ev(input int kind, input int val);
        ev_t e;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_event: got kind %0d val %0d at cycle %0d, required none", kind, val, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.val != val || e.t != cyc) begin
                miscompares++;
                $display("FAIL event: got kind %0d val %0d cycle %0d, required kind %0d val %0d cycle %0d",
                         kind, val, cyc, e.kind, e.val, e.t);
            end
        end
    endtask

    always @(negedge clk) begin
        int cur;
        if (mon_en) begin
            cur = int'({sound_enable_n, read_data});
            if (cur != mon_prev) begin
                check_ev(K_OUT, cur);
                mon_prev = cur;
            end
            if (mem_rd_en) check_ev(K_FETCH, int'(mem_addr));
            if (done) check_ev(K_DONE, 0);
            if (err) check_ev(K_ERR, 0);
            chk("busy", int'(busy), (cyc >= busy_lo && cyc <= busy_hi) ? 1 : 0);
        end
    end

    task automatic check_reset_vals(input string name);
        chk({name, "_read_data"}, int'(read_data), 0);
        chk({name, "_sound_enable_n"}, int'(sound_enable_n), 1);
        chk({name, "_mem_rd_en"}, int'(mem_rd_en), 0);
        chk({name, "_mem_addr"}, int'(mem_addr), 0);
        chk({name, "_busy"}, int'(busy), 0);
        chk({name, "_done"}, int'(done), 0);
        chk({name, "_err"}, int'(err), 0);
    endtask

    // ab_kind: 0 natural end, 1 stop driven at n+ab_off, 2 reset asserted at n+ab_off.
    task automatic run_play(input int sa, input int ea, input bit lp, input int ab_kind,
                            input int ab_off, input int ign_off, input bit stop_too);
        int n, nsmp, s_lim;
        n    = cyc;
        nsmp = ea - sa + 1;
        case (ab_kind)
            1:       s_lim = n + ab_off + 1;
            2:       s_lim = n + ab_off;
            default: s_lim = n + 2 + (nsmp + 1) * DV;
        endcase
        // Slot j starts DV*j cycles after the first fetch: shows sample j-1 and fetches sample j.
        for (int j = 0; n + 1 + j * DV < s_lim; j++) begin
            if (j >= 1 && (lp || j - 1 < nsmp))
                push_out(n + 1 + j * DV, 0, int'(mem_val(sa + (j - 1) % nsmp)));
            if (lp || j < nsmp)
                push_ev(K_FETCH, sa + j % nsmp, n + 1 + j * DV);
            if (!lp && j == nsmp + 1) begin
                push_out(n + 1 + j * DV, 1, 0);
                push_ev(K_DONE, 0, n + 1 + j * DV);
            end
        end
        if (ab_kind != 0) push_out(s_lim, 1, 0);
        busy_lo = n + 1;
        busy_hi = (ab_kind != 0) ? s_lim - 1 : n + (nsmp + 1) * DV;

        start_addr = AW'(sa);
        end_addr   = AW'(ea);
        loop_en    = lp;
        play_req   = 1'b1;
        stop_req   = stop_too;
        step();
        play_req = 1'b0;
        stop_req = 1'b0;
        while (cyc <= busy_hi) begin
            if (ign_off > 0 && cyc == n + ign_off) begin
                play_req   = 1'b1;
                start_addr = AW'($urandom);
                end_addr   = AW'($urandom);
                loop_en    = 1'($urandom);
            end
            if (ab_kind == 1 && cyc == n + ab_off) stop_req = 1'b1;
            step();
            play_req = 1'b0;
            stop_req = 1'b0;
        end
        if (ab_kind == 2) begin
            reset_n_clk = 1'b0;
            #1;
            check_reset_vals("mid_reset");
            step();
            step();
            reset_n_clk = 1'b1;
        end
    endtask

    task automatic run_err(input int sa, input int ea);
        push_ev(K_ERR, 0, cyc + 1);
        start_addr = AW'(sa);
        end_addr   = AW'(ea);
        loop_en    = 1'b0;
        play_req   = 1'b1;
        step();
        play_req = 1'b0;
    endtask

    task automatic idle(input int k, input bit stop_pulse);
        for (int i = 0; i < k; i++) begin
            stop_req = stop_pulse && (i == 0);
            step();
            stop_req = 1'b0;
        end
    endtask

    task automatic run_long();
        int n, rd_cnt, hold, first, done_t, done_cnt;
        n        = cyc;
        rd_cnt   = 0;
        hold     = 0;
        first    = -1;
        done_t   = -1;
        done_cnt = 0;
        start_l  = AW'(7);
        end_l    = AW'(7);
        loop_l   = 1'b0;
        play_l   = 1'b1;
        step();
        play_l = 1'b0;
        for (int k = 0; k < 2 * DV_LONG + 10; k++) begin
            @(negedge clk);
            if (rd_en_l) rd_cnt++;
            if (!en_n_l && read_data_l == 10'd70) begin
                hold++;
                if (first < 0) first = cyc;
            end
            if (done_l) begin
                done_cnt++;
                done_t = cyc;
            end
            step();
        end
        chk("long_rd_count", rd_cnt, 1);
        chk("long_hold_cycles", hold, DV_LONG);
        chk("long_first_sample_cycle", first, n + 1 + DV_LONG);
        chk("long_done_count", done_cnt, 1);
        chk("long_done_cycle", done_t, n + 1 + 2 * DV_LONG);
        chk("long_busy_after", int'(busy_l), 0);
    endtask

    initial begin
        #1_000_000;
        miscompares++;
        $display("FAIL watchdog: got timeout at cycle %0d, required completion", cyc);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        int sa, len, eoff, ign;
        bit lp, st;
        reset_n_clk = 1'b0;
        play_req = 1'b0; stop_req = 1'b0; loop_en = 1'b0;
        start_addr = '0; end_addr = '0;
        play_l = 1'b0; stop_l = 1'b0; loop_l = 1'b0;
        start_l = '0; end_l = '0;
        step();
        step();
        check_reset_vals("reset");
        reset_n_clk = 1'b1;
        step();
        mon_en = 1'b1;

        run_play(2, 4, 1'b0, 0, 0, 0, 1'b0);  idle(3, 1'b0);
        run_play(5, 6, 1'b1, 1, 14, 0, 1'b0); idle(3, 1'b0);
        run_err(9, 3);                        idle(3, 1'b1);
        run_play(2, 4, 1'b0, 0, 0, 6, 1'b0);  idle(2, 1'b0);
        run_play(3, 5, 1'b0, 2, 7, 0, 1'b0);  idle(2, 1'b0);
        run_play(10, 11, 1'b0, 0, 0, 0, 1'b1); idle(2, 1'b0);
        run_play(7, 7, 1'b1, 1, 10, 0, 1'b0); idle(2, 1'b0);
        run_play(8, 9, 1'b0, 1, 12, 0, 1'b0); idle(2, 1'b0);
        run_play(255, 255, 1'b0, 0, 0, 3, 1'b0); idle(2, 1'b0);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                sa = int'($urandom_range(1, 255));
                run_err(sa, int'($urandom_range(0, sa - 1)));
            end else begin
                sa   = int'($urandom_range(0, 250));
                len  = int'($urandom_range(0, 3));
                lp   = 1'($urandom_range(0, 1));
                st   = ($urandom_range(0, 3) == 0);
                eoff = (len + 2) * DV;
                ign  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, eoff)) : 0;
                if (lp)
                    run_play(sa, sa + len, 1'b1, 1, int'($urandom_range(1, 3 * (len + 1) * DV + 2)), ign, st);
                else if ($urandom_range(0, 2) == 0)
                    run_play(sa, sa + len, 1'b0, 1, int'($urandom_range(1, eoff)), ign, st);
                else
                    run_play(sa, sa + len, 1'b0, 0, 0, ign, st);
            end
            idle(int'($urandom_range(1, 3)), 1'($urandom_range(0, 1)));
        end

        run_long();
        idle(2, 1'b0);
        chk("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sound_sequencer.md
SOUND_SEQUENCER -- requirements
Module: sound_sequencer

Interface
REQ-001 Parameter ADDR_W, 16, sample memory address width.
REQ-002 Parameter DIV, 3125, clk cycles per sample period (50 MHz / 16 kHz); legal range DIV >= 4.
REQ-003 clk  input  1  system clock; all logic on its rising edge.
REQ-004 reset_n_clk  input  1  reset, asynchronous, active-low.
REQ-005 play_req  input  1  single-cycle request to start playback.
REQ-006 stop_req  input  1  single-cycle request to abort playback.
REQ-007 start_addr  input  ADDR_W  first sample address; sampled on play accept.
REQ-008 end_addr  input  ADDR_W  last sample address, inclusive; sampled on play accept.
REQ-009 loop_en  input  1  wrap to start_addr after end_addr; sampled on play accept.
REQ-010 mem_addr  output  ADDR_W  sample memory read address.
REQ-011 mem_rd_en  output  1  read strobe; mem_rdata is valid exactly 1 cycle after it.
REQ-012 mem_rdata  input  10  sample memory read data.
REQ-013 read_data  output  10  current sample to the sound player.
REQ-014 sound_enable_n  output  1  active-low enable to the sound player.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle pulse on natural end of a non-looping playback.
REQ-017 err  output  1  one-cycle pulse when play_req is rejected because start_addr > end_addr.

Function
REQ-018 FSM states are IDLE, FETCH, WAIT, HOLD and LAST.
REQ-019 IDLE: on play_req with start_addr <= end_addr, latch start_q, end_q and loop_q, set addr <= start_addr, clear the tick counter, and go to FETCH.
REQ-020 IDLE: on play_req with start_addr > end_addr, pulse err and stay in IDLE.
REQ-021 play_req in any non-IDLE state shall be ignored with no side effects.
REQ-022 FETCH: mem_rd_en = 1 and mem_addr = addr for exactly one cycle, then go to WAIT.
REQ-023 WAIT: capture mem_rdata into next_q, then go to HOLD.
REQ-024 The tick counter runs 0..DIV-1 in every non-IDLE state and wraps; tick = (cnt == DIV-1).
REQ-025 The first tick after a play accept occurs exactly DIV cycles after the accept cycle.
REQ-026 HOLD, on tick: register read_data <= next_q and sound_enable_n <= 0, then branch on addr:
- addr != end_q: addr <= addr + 1, go to FETCH.
- addr == end_q and loop_q = 1: addr <= start_q, go to FETCH.
- addr == end_q and loop_q = 0: go to LAST.
REQ-027 LAST, on tick: sound_enable_n <= 1, read_data <= 0, done pulses for one cycle, go to IDLE.
REQ-028 Each sample reaches read_data on a tick edge and holds there for exactly DIV cycles.
REQ-029 Because DIV >= 4, a refetch always completes before the next tick; ticks are never missed.
REQ-030 addr increments modulo 2^ADDR_W; no carry is propagated.
REQ-031 stop_req in any non-IDLE state: next cycle goes to IDLE with sound_enable_n = 1, read_data = 0, mem_rd_en = 0, and no done pulse.
REQ-032 stop_req in IDLE has no effect.
REQ-033 stop_req and a tick in the same cycle: stop wins.
REQ-034 play_req and stop_req in the same IDLE cycle: play is accepted (stop has no effect in IDLE).
REQ-035 start_addr == end_addr is legal: one sample is played, or repeated indefinitely if loop_en = 1.
REQ-036 mem_addr shall equal addr in all states; only mem_rd_en qualifies a read.

Reset
REQ-037 On reset assertion, immediately and asynchronously: state = IDLE, addr = 0, cnt = 0, next_q = 0, read_data = 0, sound_enable_n = 1, mem_rd_en = 0, busy = 0, done = 0, err = 0.
REQ-038 Reset mid-playback shall abort with no done pulse; the first play_req after reset deassertion is accepted normally.

Structure
REQ-039 A shared package sound_pkg shall hold the FSM state enum, SAMPLE_W = 10 and the DIV default, for reuse by sound_player.
REQ-040 The tick counter shall be the sub-module sample_tick_gen (inputs clk, reset_n_clk, clear, en; output tick).
REQ-041 All outputs shall be registered except busy, which is decoded from state.

Verification
REQ-042 DIV=4, start=2, end=4, loop=0, memory[a] = 10*a -> read_data 20, 30, 40, each held 4 cycles with sound_enable_n = 0, then read_data = 0, sound_enable_n = 1 and one done pulse.
REQ-043 DIV=4, start=5, end=6, loop=1 -> read_data sequence 50, 60, 50, 60, ...; stop_req during the third sample -> IDLE next cycle, sound_enable_n = 1, no done.
REQ-044 play_req with start=9, end=3 -> err pulses once, busy stays 0, mem_rd_en never asserts.
REQ-045 play_req while busy with different addresses -> the original sequence continues unchanged.
REQ-046 reset_n_clk asserted mid-HOLD -> all outputs take their reset values in the same cycle; a new play after reset starts from the new start_addr.
REQ-047 start=end=7, loop=0, DIV=3125 -> exactly one mem_rd_en, read_data = 70 for 3125 cycles, then done.
